// File: rtl/broken_clause_serializer_pkg.sv
// rtl/broken_clause_serializer_pkg.sv - shared widths, literal layout and scan state encoding for broken_clause_serializer
package broken_clause_serializer_pkg;

   localparam int NSAT                     = 3;
   localparam int LITERAL_ADDRESS_WIDTH    = 11;
   localparam int LITERAL_WIDTH            = LITERAL_ADDRESS_WIDTH + 1;
   localparam int MAX_CLAUSES_PER_VARIABLE = 20;
   localparam int SLOT_BITS                = 5;
   localparam int FIFO_DEPTH               = 8;
   localparam int FIFO_ADDR_BITS           = 3;

   // One clause is NSAT literals, each a sign bit above its address.
   localparam int CW       = NSAT * LITERAL_WIDTH;
   localparam int SIGN_BIT = LITERAL_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/broken_clause_serializer_clause_fifo.sv
// rtl/broken_clause_serializer_clause_fifo.sv - synchronous clause FIFO with registered storage and occupancy count
module broken_clause_serializer_clause_fifo #(
   parameter int WIDTH     = 36,
   parameter int DEPTH     = 8,
   parameter int ADDR_BITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam logic [ADDR_BITS:0] FULL_OCC = (ADDR_BITS + 1)'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] wptr;
   logic [ADDR_BITS-1:0] rptr;
   logic [ADDR_BITS:0]   occ;
   logic                 do_push;
   logic                 do_pop;

   assign full     = (occ == FULL_OCC);
   assign empty    = (occ == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rptr];

   // Storage is not reset; only entries below the occupancy are ever observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy is unchanged on simultaneous push and pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/broken_clause_serializer.sv
// rtl/broken_clause_serializer.sv - captures clause slots, streams non-zero ones through a FIFO (option: BROKEN_CLAUSE_SERIALIZER_DEDUP_EN)
module broken_clause_serializer
   import broken_clause_serializer_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   load_i,
   input  logic [MAX_CLAUSES_PER_VARIABLE*CW-1:0] clause_multi_i,
   output logic                                   load_ready_o,
   output logic [CW-1:0]                          clause_o,
   output logic                                   clause_valid_o,
   input  logic                                   clause_ready_i,
   output logic                                   done_o,
   output logic [SLOT_BITS-1:0]                   broken_count_o
);

   localparam logic [SLOT_BITS-1:0] LAST_IDX = SLOT_BITS'(MAX_CLAUSES_PER_VARIABLE - 1);

   state_t                                 state_q;
   state_t                                 state_d;
   logic [SLOT_BITS-1:0]                   idx_q;
   logic [SLOT_BITS-1:0]                   idx_d;
   logic [SLOT_BITS-1:0]                   count_q;
   logic [SLOT_BITS-1:0]                   count_d;
   logic [SLOT_BITS-1:0]                   broken_count_q;
   logic [MAX_CLAUSES_PER_VARIABLE*CW-1:0] capture_q;
   logic [CW-1:0]                          slot;
   logic                                   is_dup;
   logic                                   skip;
   logic                                   push;
   logic                                   accept_load;
   logic                                   fifo_full;
   logic                                   fifo_empty;

   assign slot        = capture_q[int'(idx_q) * CW +: CW];
   assign accept_load = (state_q == IDLE) && load_i;
   assign skip        = (slot == '0) || is_dup;

`ifdef BROKEN_CLAUSE_SERIALIZER_DEDUP_EN
   logic [CW-1:0] last_q;

   // A cleared last-pushed value can never match a non-zero slot, so no separate valid flag is needed.
   assign is_dup = (slot == last_q);

   // Track the most recent clause pushed during the current scan.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= '0;
      end else if (accept_load) begin
         last_q <= '0;
      end else if (push) begin
         last_q <= slot;
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   // Next-state and scan datapath: skip empty slots, push broken ones, stall on a full FIFO.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               state_d = SCAN;
               idx_d   = '0;
               count_d = '0;
            end
         end
         SCAN: begin
            // Full is judged at cycle start, so a pop in this cycle does not release the stall.
            if (skip || !fifo_full) begin
               if (!skip) begin
                  push    = 1'b1;
                  count_d = count_q + 1'b1;
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scan state, index, running count and the published count, which lands with done_o.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         count_q        <= '0;
         broken_count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         if ((state_q == SCAN) && (state_d == DONE)) begin
            broken_count_q <= count_d;
         end
      end
   end

   // Capture register: loaded only when a load is accepted in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         capture_q <= '0;
      end else if (accept_load) begin
         capture_q <= clause_multi_i;
      end
   end

   broken_clause_serializer_clause_fifo #(
      .WIDTH     (CW),
      .DEPTH     (FIFO_DEPTH),
      .ADDR_BITS (FIFO_ADDR_BITS)
   ) u_clause_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (slot),
      .pop       (clause_valid_o && clause_ready_i),
      .pop_data  (clause_o),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign clause_valid_o = !fifo_empty;
   assign load_ready_o   = (state_q == IDLE);
   assign done_o         = (state_q == DONE);
   assign broken_count_o = broken_count_q;

endmodule

// File: tb/tb_broken_clause_serializer.sv
// tb/tb_broken_clause_serializer.sv - randomized self-checking bench for broken_clause_serializer
module tb_broken_clause_serializer;
   import broken_clause_serializer_pkg::*;

   localparam int MAXC = MAX_CLAUSES_PER_VARIABLE;

`ifdef BROKEN_CLAUSE_SERIALIZER_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 load_i;
   logic [MAXC*CW-1:0]   clause_multi_i;
   logic                 load_ready_o;
   logic [CW-1:0]        clause_o;
   logic                 clause_valid_o;
   logic                 clause_ready_i;
   logic                 done_o;
   logic [SLOT_BITS-1:0] broken_count_o;

   int n_pass  = 0;
   int n_total = 0;
   int done_count = 0;

   logic [CW-1:0] slots [MAXC];
   logic [CW-1:0] exp_q [$];
   logic [CW-1:0] got_q [$];

   broken_clause_serializer dut (
      .clk            (clk),
      .reset          (reset),
      .load_i         (load_i),
      .clause_multi_i (clause_multi_i),
      .load_ready_o   (load_ready_o),
      .clause_o       (clause_o),
      .clause_valid_o (clause_valid_o),
      .clause_ready_i (clause_ready_i),
      .done_o         (done_o),
      .broken_count_o (broken_count_o)
   );

   always #5 clk = ~clk;

   // Record every accepted clause and every done pulse.
   always @(negedge clk) begin
      if (reset) begin
         if (clause_valid_o && clause_ready_i) got_q.push_back(clause_o);
         if (done_o) done_count++;
      end
   end

   function automatic logic [CW-1:0] rand_clause();
      logic [CW-1:0] v;
      v = CW'({$urandom(), $urandom()});
      if (v == '0) v = CW'(1);
      return v;
   endfunction

   // Reference: the stream a capture must produce, appended to the expected queue.
   task automatic model_scan(output int n);
      logic [CW-1:0] last;
      bit have_last;
      n = 0;
      have_last = 1'b0;
      last = '0;
      for (int k = 0; k < MAXC; k++) begin
         if (slots[k] != '0 && !(DEDUP && have_last && slots[k] == last)) begin
            exp_q.push_back(slots[k]);
            n++;
            last = slots[k];
            have_last = 1'b1;
         end
      end
   endtask

   task automatic clear_slots();
      for (int k = 0; k < MAXC; k++) slots[k] = '0;
   endtask

   task automatic do_load(output int n);
      logic [MAXC*CW-1:0] bus;
      for (int k = 0; k < MAXC; k++) bus[k*CW +: CW] = slots[k];
      model_scan(n);
      @(posedge clk); #1;
      clause_multi_i = bus;
      load_i = 1'b1;
      @(posedge clk); #1;
      load_i = 1'b0;
   endtask

   // Returns at the negedge of the done cycle; cyc counts cycles after the load cycle.
   task automatic wait_done(input int bound, input bit rand_ready, output int cyc, output bit seen);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (done_o) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            if (rand_ready) clause_ready_i = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic drain(input int bound);
      int c;
      c = 0;
      @(posedge clk); #1;
      clause_ready_i = 1'b1;
      while (got_q.size() < exp_q.size() && c < bound) begin
         @(posedge clk); #1;
         c++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic compare_stream(input string name);
      n_total++;
      if (got_q.size() !== exp_q.size()) begin
         $display("FAIL %s_count: got %0d clauses, required %0d", name, got_q.size(), exp_q.size());
      end else begin
         n_pass++;
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL %s_order[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      load_i = 1'b0;
      clause_ready_i = 1'b0;
      clause_multi_i = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_total++;
      if ({clause_valid_o, done_o, load_ready_o, broken_count_o} !== {1'b0, 1'b0, 1'b1, SLOT_BITS'(0)})
         $display("FAIL reset_state: valid=%b done=%b ready=%b count=%0d, required 0 0 1 0",
                  clause_valid_o, done_o, load_ready_o, broken_count_o);
      else n_pass++;
   endtask

   task automatic test_sparse();
      int n, cyc;
      bit seen;
      clear_slots();
      slots[2] = rand_clause();
      slots[7] = rand_clause();
      slots[19] = rand_clause();
      clause_ready_i = 1'b1;
      do_load(n);
      wait_done(100, 1'b0, cyc, seen);
      n_total++;
      if (!seen || cyc != MAXC + 1) $display("FAIL sparse_latency: seen=%b cycles=%0d, required %0d", seen, cyc, MAXC + 1);
      else n_pass++;
      n_total++;
      if (broken_count_o !== SLOT_BITS'(3)) $display("FAIL sparse_count: got %0d, required 3", broken_count_o);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (done_o !== 1'b0 || load_ready_o !== 1'b1) $display("FAIL sparse_done_pulse: done=%b ready=%b, required 0 1", done_o, load_ready_o);
      else n_pass++;
      drain(100);
      compare_stream("sparse");
   endtask

   task automatic test_reset_mid_scan();
      int n;
      for (int k = 0; k < MAXC; k++) slots[k] = rand_clause();
      clause_ready_i = 1'b0;
      do_load(n);
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_total++;
      if (clause_valid_o !== 1'b0 || load_ready_o !== 1'b1 || done_o !== 1'b0)
         $display("FAIL midscan_reset: valid=%b ready=%b done=%b, required 0 1 0", clause_valid_o, load_ready_o, done_o);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_total++;
      if (broken_count_o !== '0 || clause_valid_o !== 1'b0)
         $display("FAIL midscan_release: count=%0d valid=%b, required 0 0", broken_count_o, clause_valid_o);
      else n_pass++;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_stall();
      int n, cyc, d0;
      bit seen;
      for (int k = 0; k < MAXC; k++) slots[k] = rand_clause();
      slots[10] = slots[9] ^ CW'(1);
      clause_ready_i = 1'b0;
      d0 = done_count;
      do_load(n);
      repeat (30) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (done_count != d0 || got_q.size() != 0 || clause_valid_o !== 1'b1 || load_ready_o !== 1'b0)
         $display("FAIL stall_hold: dones=%0d popped=%0d valid=%b ready=%b, required 0 0 1 0",
                  done_count - d0, got_q.size(), clause_valid_o, load_ready_o);
      else n_pass++;
      @(posedge clk); #1;
      clause_ready_i = 1'b1;
      wait_done(200, 1'b0, cyc, seen);
      n_total++;
      if (!seen || broken_count_o !== SLOT_BITS'(MAXC))
         $display("FAIL stall_count: seen=%b count=%0d, required 1 %0d", seen, broken_count_o, MAXC);
      else n_pass++;
      drain(100);
      compare_stream("stall");
   endtask

   task automatic test_load_ignored();
      int n, cyc;
      bit seen, busy_ok;
      logic [MAXC*CW-1:0] other;
      clear_slots();
      for (int k = 0; k < MAXC; k += 3) slots[k] = rand_clause();
      for (int k = 0; k < MAXC; k++) other[k*CW +: CW] = rand_clause();
      clause_ready_i = 1'b1;
      do_load(n);
      cyc = 0;
      seen = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done_o) seen = 1'b1;
         if (load_ready_o !== 1'b0) busy_ok = 1'b0;
         if (!seen) begin
            @(posedge clk); #1;
            load_i = (cyc == 3);
            if (cyc == 3) clause_multi_i = other;
         end
      end
      n_total++;
      if (!busy_ok || !seen || cyc != MAXC + 1)
         $display("FAIL busy_ready: ready_low_ok=%b seen=%b cycles=%0d, required 1 1 %0d", busy_ok, seen, cyc, MAXC + 1);
      else n_pass++;
      n_total++;
      if (broken_count_o !== SLOT_BITS'(n)) $display("FAIL busy_count: got %0d, required %0d", broken_count_o, n);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (load_ready_o !== 1'b1 || done_o !== 1'b0) $display("FAIL busy_after_done: ready=%b done=%b, required 1 0", load_ready_o, done_o);
      else n_pass++;
      drain(100);
      compare_stream("busy");
   endtask

   task automatic test_back_to_back();
      int n, cyc;
      bit seen;
      clear_slots();
      slots[$urandom_range(0, 5)] = rand_clause();
      slots[$urandom_range(6, 12)] = rand_clause();
      slots[$urandom_range(13, 19)] = rand_clause();
      clause_ready_i = 1'b0;
      do_load(n);
      wait_done(100, 1'b0, cyc, seen);
      for (int k = 0; k < MAXC; k++) slots[k] = ($urandom_range(0, 1) != 0) ? rand_clause() : '0;
      do_load(n);
      wait_done(500, 1'b1, cyc, seen);
      n_total++;
      if (!seen || broken_count_o !== SLOT_BITS'(n))
         $display("FAIL b2b_count: seen=%b count=%0d, required 1 %0d", seen, broken_count_o, n);
      else n_pass++;
      drain(100);
      compare_stream("b2b");
   endtask

   task automatic test_dedup();
      int n, cyc;
      bit seen;
      logic [CW-1:0] pat;
      pat = 36'h000800801;
      clear_slots();
      slots[0] = pat;
      slots[1] = pat;
      slots[4] = pat ^ rand_clause();
      if (slots[4] == '0) slots[4] = ~pat;
      clause_ready_i = 1'b1;
      do_load(n);
      wait_done(100, 1'b0, cyc, seen);
      n_total++;
      if (!seen || broken_count_o !== SLOT_BITS'(DEDUP ? 2 : 3))
         $display("FAIL dedup_count: seen=%b count=%0d, required 1 %0d", seen, broken_count_o, DEDUP ? 2 : 3);
      else n_pass++;
      drain(100);
      compare_stream("dedup");
   endtask

   task automatic test_random();
      int n, cyc, pct;
      bit seen;
      for (int it = 0; it < 8; it++) begin
         pct = $urandom_range(0, 100);
         for (int k = 0; k < MAXC; k++) begin
            if ($urandom_range(1, 100) <= pct) slots[k] = rand_clause();
            else slots[k] = '0;
            if (k > 0 && $urandom_range(0, 4) == 0) slots[k] = slots[k-1];
         end
         do_load(n);
         wait_done(1000, 1'b1, cyc, seen);
         n_total++;
         if (!seen || broken_count_o !== SLOT_BITS'(n))
            $display("FAIL random_count[%0d]: seen=%b count=%0d, required 1 %0d", it, seen, broken_count_o, n);
         else n_pass++;
      end
      drain(400);
      compare_stream("random");
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_reset_mid_scan();
      test_stall();
      test_load_ignored();
      test_back_to_back();
      test_dedup();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
